// File: rtl/cpu_issue_pkg.sv
// ============================================================================
// Module : cpu_issue_pkg
// Brief  : Shared types and constants for the cpu instruction issue controller
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_issue_pkg;

  localparam int INSTR_W = 16;
  localparam int FLAG_W  = 3;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/issue_fifo.sv
// ============================================================================
// Module : issue_fifo
// Brief  : Synchronous instruction FIFO with first-word-fall-through head
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int CNTW = AW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // Full is judged before any same-cycle pop, so a push at full is dropped.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_issue_ctrl.sv
// ============================================================================
// Module : cpu_issue_ctrl
// Brief  : Issues queued instructions to the cpu via load/s/w handshake
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_issue_ctrl
  import cpu_issue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [INSTR_W-1:0] i_wr_data,
  output logic               o_full,
  output logic               o_empty,
  input  logic               i_run,
  output logic               o_busy,
  output logic [INSTR_W-1:0] o_cpu_in,
  output logic               o_cpu_load,
  output logic               o_cpu_s,
  input  logic               i_cpu_w,
  input  logic [INSTR_W-1:0] i_cpu_out,
  input  logic               i_cpu_N,
  input  logic               i_cpu_V,
  input  logic               i_cpu_Z,
  output logic [INSTR_W-1:0] o_res_out,
  output logic [FLAG_W-1:0]  o_res_flags,
  output logic               o_res_valid,
  output logic [CW-1:0]      o_issued_cnt,
  output logic               o_timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  issue_state_t       r_state;
  issue_state_t       w_next;
  logic               w_pop;
  logic               w_done;
  logic               w_timeout;
  logic               w_tmo_hit;
  logic [INSTR_W-1:0] w_head;
  logic [FLAG_W-1:0]  w_flags;
  logic [TW-1:0]      r_tmo;

  logic [INSTR_W-1:0] r_cpu_in;
  logic               r_cpu_load;
  logic               r_cpu_s;
  logic               r_busy;
  logic [INSTR_W-1:0] r_res_out;
  logic [FLAG_W-1:0]  r_res_flags;
  logic               r_res_valid;
  logic [CW-1:0]      r_issued_cnt;
  logic               r_timeout_err;

  issue_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_wr_en),
    .i_data  (i_wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  // Hit on the last permitted cycle of a wait state.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = i_cpu_N;
    w_flags[FLAG_V] = i_cpu_V;
    w_flags[FLAG_Z] = i_cpu_Z;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_run && !o_empty && i_cpu_w && !r_timeout_err) begin
          w_next = LOAD;
          w_pop  = 1'b1;
        end
      end
      LOAD:  w_next = START;
      START: w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!i_cpu_w) begin
          w_next = WAIT_DONE;
        end else if (w_tmo_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i_cpu_w) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (w_tmo_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tmo         <= '0;
      r_cpu_in      <= '0;
      r_cpu_load    <= 1'b0;
      r_cpu_s       <= 1'b0;
      r_busy        <= 1'b0;
      r_res_out     <= '0;
      r_res_flags   <= '0;
      r_res_valid   <= 1'b0;
      r_issued_cnt  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_load  <= (w_next == LOAD);
      r_cpu_s     <= (w_next == START);
      r_busy      <= (w_next != IDLE);
      r_res_valid <= w_done;
      if (w_pop) r_cpu_in <= w_head;
      if (r_state == START || (r_state == WAIT_BUSY && !i_cpu_w)) begin
        r_tmo <= '0;
      end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_done) begin
        r_res_out    <= i_cpu_out;
        r_res_flags  <= w_flags;
        r_issued_cnt <= r_issued_cnt + CW'(1);
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign o_cpu_in      = r_cpu_in;
  assign o_cpu_load    = r_cpu_load;
  assign o_cpu_s       = r_cpu_s;
  assign o_busy        = r_busy;
  assign o_res_out     = r_res_out;
  assign o_res_flags   = r_res_flags;
  assign o_res_valid   = r_res_valid;
  assign o_issued_cnt  = r_issued_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire
